// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, word type,
// and the arbiter's FSM and grant encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } arb_state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between icache and dcache requests.
// Registered grant, round-robin tie-break, per-access watchdog.
import cpu_types_pkg::*;

module memory_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter word_t       ERRWORD = 32'hBAD1BAD1
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      timeout
);

    localparam logic [7:0] TLIM = 8'(TIMEOUT);

    arb_state_t state, nxt;
    grant_t     last;
    word_t      addr_q, store_q;
    logic       wen_q;
    logic [7:0] cnt;
    logic       tmo_q;

    logic  dreq, ireq, serv, abort, acc, expire, done, pick_d;
    word_t rdata;

    assign dreq   = dREN | dWEN;
    assign ireq   = iREN;
    assign serv   = (state != IDLE);
    assign acc    = (ramstate == ACCESS);
    assign expire = (cnt >= TLIM);
    assign abort  = (state == DSERV && !dreq) ||
                    (state == ISERV && !ireq);
    assign done   = serv && !abort && (acc || expire);
    assign rdata  = acc ? ramload : ERRWORD;

    // Next-state and grant selection; data wins ties when instr went last.
    always_comb begin
        nxt    = state;
        pick_d = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                if (dreq && ireq) pick_d = (last == INSTR);
                else              pick_d = dreq;
                if (dreq || ireq) nxt = pick_d ? DSERV : ISERV;
            end
            default: begin
                if (abort || done) nxt = IDLE;
            end
        endcase
    end

    assign ramREN   = serv && !wen_q;
    assign ramWEN   = serv && wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign dwait    = !(done && state == DSERV);
    assign iwait    = !(done && state == ISERV);
    assign dload    = (done && state == DSERV) ? rdata : '0;
    assign iload    = (done && state == ISERV) ? rdata : '0;
    assign timeout  = tmo_q;

    // State, request latch, saturating watchdog counter, sticky flag.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= IDLE;
            last    <= INSTR;
            addr_q  <= '0;
            store_q <= '0;
            wen_q   <= 1'b0;
            cnt     <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE) begin
                cnt <= '0;
                if (dreq || ireq) begin
                    addr_q  <= pick_d ? daddr : iaddr;
                    store_q <= pick_d ? dstore : '0;
                    wen_q   <= pick_d && dWEN;
                end
            end else if (!acc && cnt != 8'hFF) begin
                cnt <= cnt + 8'd1;
            end
            if (done) last <= (state == DSERV) ? DATA : INSTR;
            if (serv && !abort && !acc && expire) tmo_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reads, contention,
// write priority, watchdog, abort, reset and ERROR retry.
import cpu_types_pkg::*;

module tb_memory_arbiter;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    logic      iwait, dwait, ramREN, ramWEN, timeout;
    word_t     iload, dload, ramaddr, ramstore;
    ramstate_t ramstate;

    int n_cmp = 0;
    int n_mis = 0;

    memory_arbiter #(.TIMEOUT(4), .ERRWORD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        #3;
    endtask

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;

        // reset values
        nxt(); nxt(); smp();
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);
        chk("rst_ren", ramREN, 0);
        chk("rst_wen", ramWEN, 0);
        chk("rst_addr", ramaddr, 0);
        chk("rst_store", ramstore, 0);
        chk("rst_tmo", timeout, 0);
        nxt(); nRST = 1;

        // instruction read, 2 BUSY then ACCESS
        nxt(); iREN = 1; iaddr = 32'h40; smp();
        chk("ir_c0_ren", ramREN, 0);
        nxt(); ramstate = BUSY; smp();
        chk("ir_c1_ren", ramREN, 1);
        chk("ir_c1_addr", ramaddr, 32'h40);
        chk("ir_c1_iwait", iwait, 1);
        nxt(); smp();
        chk("ir_c2_ren", ramREN, 1);
        chk("ir_c2_iwait", iwait, 1);
        nxt(); ramstate = ACCESS; ramload = 32'h8C010004; smp();
        chk("ir_c3_ren", ramREN, 1);
        chk("ir_c3_iwait", iwait, 0);
        chk("ir_c3_iload", iload, 32'h8C010004);
        chk("ir_c3_dwait", dwait, 1);
        nxt(); iREN = 0; ramstate = FREE; smp();
        chk("ir_c4_iwait", iwait, 1);
        chk("ir_c4_iload", iload, 0);
        chk("ir_c4_ren", ramREN, 0);

        // contention: D, I, D
        nxt(); iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h200;
        ramstate = ACCESS; ramload = 32'h11111111; smp();
        chk("ct_c0_ren", ramREN, 0);
        nxt(); smp();
        chk("ct_c1_dwait", dwait, 0);
        chk("ct_c1_dload", dload, 32'h11111111);
        chk("ct_c1_iwait", iwait, 1);
        chk("ct_c1_addr", ramaddr, 32'h200);
        nxt(); smp();
        chk("ct_c2_dwait", dwait, 1);
        chk("ct_c2_ren", ramREN, 0);
        nxt(); smp();
        chk("ct_c3_iwait", iwait, 0);
        chk("ct_c3_iload", iload, 32'h11111111);
        chk("ct_c3_dwait", dwait, 1);
        chk("ct_c3_addr", ramaddr, 32'h44);
        nxt(); smp();
        chk("ct_c4_ren", ramREN, 0);
        nxt(); smp();
        chk("ct_c5_dwait", dwait, 0);
        chk("ct_c5_iwait", iwait, 1);
        chk("ct_c5_addr", ramaddr, 32'h200);
        nxt(); iREN = 0; dREN = 0; ramstate = FREE; smp();
        chk("ct_c6_ren", ramREN, 0);

        // write wins over read
        nxt(); dREN = 1; dWEN = 1; daddr = 32'h100;
        dstore = 32'hDEADBEEF; ramstate = BUSY;
        nxt(); smp();
        chk("wr_c1_wen", ramWEN, 1);
        chk("wr_c1_ren", ramREN, 0);
        chk("wr_c1_store", ramstore, 32'hDEADBEEF);
        chk("wr_c1_addr", ramaddr, 32'h100);
        chk("wr_c1_dwait", dwait, 1);
        nxt(); ramstate = ACCESS; smp();
        chk("wr_c2_dwait", dwait, 0);
        nxt(); dREN = 0; dWEN = 0; ramstate = FREE; smp();
        chk("wr_c3_wen", ramWEN, 0);

        // watchdog with TIMEOUT=4
        nxt(); dREN = 1; daddr = 32'h300; ramstate = BUSY;
        for (int c = 1; c <= 4; c++) begin
            nxt(); smp();
            chk($sformatf("wd_c%0d_dwait", c), dwait, 1);
            chk($sformatf("wd_c%0d_tmo", c), timeout, 0);
        end
        nxt(); smp();
        chk("wd_c5_dwait", dwait, 0);
        chk("wd_c5_dload", dload, 32'hBAD1BAD1);
        nxt(); dREN = 0; ramstate = FREE; smp();
        chk("wd_c6_tmo", timeout, 1);
        chk("wd_c6_ren", ramREN, 0);
        nxt(); iREN = 1; iaddr = 32'h48;
        ramstate = ACCESS; ramload = 32'h22222222;
        nxt(); smp();
        chk("wd_ok_iwait", iwait, 0);
        chk("wd_ok_iload", iload, 32'h22222222);
        nxt(); iREN = 0; ramstate = FREE; smp();
        chk("wd_ok_tmo", timeout, 1);

        // abort by dropping dREN mid-access
        nxt(); dREN = 1; daddr = 32'h400; ramstate = BUSY;
        nxt(); smp();
        chk("ab_c1_ren", ramREN, 1);
        nxt(); dREN = 0; smp();
        chk("ab_c2_dwait", dwait, 1);
        nxt(); smp();
        chk("ab_c3_ren", ramREN, 0);
        chk("ab_c3_dwait", dwait, 1);
        ramstate = FREE;

        // reset mid-ISERV
        nxt(); iREN = 1; iaddr = 32'h80; ramstate = BUSY;
        nxt(); smp();
        chk("rs_c1_ren", ramREN, 1);
        chk("rs_c1_tmo", timeout, 1);
        nxt(); nRST = 0;
        nxt(); iREN = 0; smp();
        chk("rs_c3_ren", ramREN, 0);
        chk("rs_c3_iwait", iwait, 1);
        chk("rs_c3_iload", iload, 0);
        chk("rs_c3_addr", ramaddr, 0);
        chk("rs_c3_store", ramstore, 0);
        chk("rs_c3_tmo", timeout, 0);
        nxt(); nRST = 1; ramstate = FREE;

        // ERROR x3 then ACCESS
        nxt(); iREN = 1; iaddr = 32'h84; ramstate = ERROR;
        for (int c = 1; c <= 3; c++) begin
            nxt(); smp();
            chk($sformatf("er_c%0d_iwait", c), iwait, 1);
            chk($sformatf("er_c%0d_ren", c), ramREN, 1);
        end
        nxt(); ramstate = ACCESS; ramload = 32'h33333333; smp();
        chk("er_c4_iwait", iwait, 0);
        chk("er_c4_iload", iload, 32'h33333333);
        nxt(); iREN = 0; ramstate = FREE; smp();
        chk("er_c5_iwait", iwait, 1);
        chk("er_c5_tmo", timeout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
